memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage_if.sv | 40 ++++
 rtl/memory_stage.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/memory_stage_if.sv
// EX/MEM entry, data-memory port and MEM/WB register of the memory stage.
// The master modport is the stage itself; slave is the surrounding pipeline/memory.
interface memory_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
);
  logic              ex_valid;
  logic [DATA_W-1:0] ex_alu_result;
  logic [DATA_W-1:0] ex_store_data;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_reg_write;
  logic [REG_W-1:0]  ex_write_reg;
  logic              stall;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;
  logic              wb_valid;
  logic              wb_reg_write;
  logic [DATA_W-1:0] wb_data;
  logic [REG_W-1:0]  wb_write_reg;
  logic              mem_err;

  modport master (
    input  ex_valid, ex_alu_result, ex_store_data, ex_mem_read, ex_mem_write,
           ex_reg_write, ex_write_reg, dmem_ack, dmem_rdata,
    output stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           wb_valid, wb_reg_write, wb_data, wb_write_reg, mem_err
  );

  modport slave (
    output ex_valid, ex_alu_result, ex_store_data, ex_mem_read, ex_mem_write,
           ex_reg_write, ex_write_reg, dmem_ack, dmem_rdata,
    input  stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           wb_valid, wb_reg_write, wb_data, wb_write_reg, mem_err
  );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: ALU results pass straight to MEM/WB, loads/stores
// hold the pipeline in ACCESS until the memory acks or the wait times out.
module memory_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 3,
  parameter int TIMEOUT = 15
) (
  input logic           clk,
  input logic           rst,
  memory_stage_if.master bus
);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, ACCESS} stateT;

  stateT             state, stateNext;
  logic [CNT_W-1:0]  waitCnt, waitCntNext;
  logic [DATA_W-1:0] capAddr, capAddrNext;
  logic [DATA_W-1:0] capWdata, capWdataNext;
  logic              capWe, capWeNext;
  logic              capLoad, capLoadNext;
  logic              capRegWrite, capRegWriteNext;
  logic [REG_W-1:0]  capWriteReg, capWriteRegNext;
  logic              wbValid, wbValidNext;
  logic              wbRegWrite, wbRegWriteNext;
  logic [DATA_W-1:0] wbData, wbDataNext;
  logic [REG_W-1:0]  wbWriteReg, wbWriteRegNext;
  logic              memErr, memErrNext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waitCnt     <= '0;
      capAddr     <= '0;
      capWdata    <= '0;
      capWe       <= 1'b0;
      capLoad     <= 1'b0;
      capRegWrite <= 1'b0;
      capWriteReg <= '0;
      wbValid     <= 1'b0;
      wbRegWrite  <= 1'b0;
      wbData      <= '0;
      wbWriteReg  <= '0;
      memErr      <= 1'b0;
    end else begin
      waitCnt     <= waitCntNext;
      capAddr     <= capAddrNext;
      capWdata    <= capWdataNext;
      capWe       <= capWeNext;
      capLoad     <= capLoadNext;
      capRegWrite <= capRegWriteNext;
      capWriteReg <= capWriteRegNext;
      wbValid     <= wbValidNext;
      wbRegWrite  <= wbRegWriteNext;
      wbData      <= wbDataNext;
      wbWriteReg  <= wbWriteRegNext;
      memErr      <= memErrNext;
    end
  end

  always_comb begin
    stateNext       = state;
    waitCntNext     = waitCnt;
    capAddrNext     = capAddr;
    capWdataNext    = capWdata;
    capWeNext       = capWe;
    capLoadNext     = capLoad;
    capRegWriteNext = capRegWrite;
    capWriteRegNext = capWriteReg;
    wbValidNext     = 1'b0;
    wbRegWriteNext  = wbRegWrite;
    wbDataNext      = wbData;
    wbWriteRegNext  = wbWriteReg;
    memErrNext      = memErr;
    case (state)
      IDLE: begin
        if (bus.ex_valid) begin
          if (bus.ex_mem_read || bus.ex_mem_write) begin
            stateNext       = ACCESS;
            waitCntNext     = '0;
            capAddrNext     = bus.ex_alu_result;
            capWdataNext    = bus.ex_store_data;
            // A read+write request is malformed: treat it as a store and flag it
            capWeNext       = bus.ex_mem_write;
            capLoadNext     = bus.ex_mem_read && !bus.ex_mem_write;
            capRegWriteNext = bus.ex_reg_write;
            capWriteRegNext = bus.ex_write_reg;
            if (bus.ex_mem_read && bus.ex_mem_write) begin
              memErrNext = 1'b1;
            end
          end else begin
            wbValidNext    = 1'b1;
            wbDataNext     = bus.ex_alu_result;
            wbRegWriteNext = bus.ex_reg_write;
            wbWriteRegNext = bus.ex_write_reg;
          end
        end
      end
      ACCESS: begin
        if (bus.dmem_ack) begin
          stateNext      = IDLE;
          wbValidNext    = 1'b1;
          wbWriteRegNext = capWriteReg;
          if (capLoad) begin
            wbDataNext     = bus.dmem_rdata;
            wbRegWriteNext = capRegWrite;
          end else begin
            wbDataNext     = capAddr;
            wbRegWriteNext = 1'b0;
          end
        end else if (waitCnt == CNT_W'(TIMEOUT)) begin
          // Abandoned access: retire without a register write
          stateNext      = IDLE;
          wbValidNext    = 1'b1;
          wbDataNext     = capAddr;
          wbRegWriteNext = 1'b0;
          wbWriteRegNext = capWriteReg;
          memErrNext     = 1'b1;
        end else begin
          waitCntNext = waitCnt + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.stall        = (state == ACCESS);
  assign bus.dmem_req     = (state == ACCESS);
  assign bus.dmem_we      = (state == ACCESS) && capWe;
  assign bus.dmem_addr    = capAddr;
  assign bus.dmem_wdata   = capWdata;
  assign bus.wb_valid     = wbValid;
  assign bus.wb_reg_write = wbRegWrite;
  assign bus.wb_data      = wbData;
  assign bus.wb_write_reg = wbWriteReg;
  assign bus.mem_err      = memErr;
endmodule
